regfile_opfetch: RTL and testbench

REGFILE_OPFETCH -- requirements
Module: regfile_opfetch

---
 rtl/regfile_opfetch.sv | 130 +++++++++++++
 tb/tb_regfile_opfetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_opfetch.sv
// Operand fetch stage: regfile read issue, same-cycle writeback bypass, 2-entry output FIFO.
// Optional REGFILE_OPFETCH_X0_ZERO_EN makes register 0 read as zero and ignore writes.
module regfile_opfetch #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DEPTH_LOG2-1:0] in_rs1_addr,
  input  logic [DEPTH_LOG2-1:0] in_rs2_addr,
  input  logic                  in_use_rs1,
  input  logic                  in_use_rs2,
  input  logic                  wb_valid,
  input  logic [DEPTH_LOG2-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  output logic                  rs1_read,
  output logic [DEPTH_LOG2-1:0] rs1_addr,
  input  logic [WIDTH-1:0]      rs1_rdata,
  output logic                  rs2_read,
  output logic [DEPTH_LOG2-1:0] rs2_addr,
  input  logic [WIDTH-1:0]      rs2_rdata,
  output logic                  rd_write,
  output logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_rs1_data,
  output logic [WIDTH-1:0]      out_rs2_data
);

  logic                  pend_q, pend_d;
  logic                  use1_q, use2_q;
  logic                  hit1_q, hit2_q;
  logic [WIDTH-1:0]      byp1_q, byp2_q;
  logic [1:0]            occ_q, occ_d;
  logic                  wr_q, rd_q;
  logic [1:0][WIDTH-1:0] f1_q, f2_q;

  logic             use1, use2, wb_en;
  logic             fire, pop, room;
  logic             hit1, hit2;
  logic [WIDTH-1:0] op1, op2;

`ifdef REGFILE_OPFETCH_X0_ZERO_EN
  assign use1  = in_use_rs1 && (in_rs1_addr != '0);
  assign use2  = in_use_rs2 && (in_rs2_addr != '0);
  assign wb_en = wb_valid && (wb_addr != '0);
`else
  assign use1  = in_use_rs1;
  assign use2  = in_use_rs2;
  assign wb_en = wb_valid;
`endif

  // occ + pend < 2; the pop term lets a full FIFO accept in its pop cycle
  assign room      = (occ_q == 2'd0) || ((occ_q == 2'd1) && !pend_q);
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = rst_n && (room || pop);
  assign fire      = in_valid && in_ready;

  assign rs1_read = fire && use1;
  assign rs2_read = fire && use2;
  assign rs1_addr = in_rs1_addr;
  assign rs2_addr = in_rs2_addr;

  assign rd_write = rst_n && wb_en;
  assign rd_addr  = wb_addr;
  assign rd_wdata = wb_data;

  // a write in the issue cycle is invisible to the regfile read, so capture it
  assign hit1 = wb_en && (wb_addr == in_rs1_addr);
  assign hit2 = wb_en && (wb_addr == in_rs2_addr);

  assign op1 = !use1_q ? '0 : (hit1_q ? byp1_q : rs1_rdata);
  assign op2 = !use2_q ? '0 : (hit2_q ? byp2_q : rs2_rdata);

  assign out_rs1_data = out_valid ? f1_q[rd_q] : '0;
  assign out_rs2_data = out_valid ? f2_q[rd_q] : '0;

  // occupancy: push of the pending token, pop by the consumer
  always_comb begin
    pend_d = fire;
    occ_d  = occ_q;
    unique case ({pend_q, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // pending token, bypass capture, FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      use1_q <= 1'b0;
      use2_q <= 1'b0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      byp1_q <= '0;
      byp2_q <= '0;
      occ_q  <= 2'd0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      f1_q   <= '0;
      f2_q   <= '0;
    end else begin
      pend_q <= pend_d;
      occ_q  <= occ_d;
      if (fire) begin
        use1_q <= use1;
        use2_q <= use2;
        hit1_q <= hit1;
        hit2_q <= hit2;
        byp1_q <= wb_data;
        byp2_q <= wb_data;
      end
      if (pend_q) begin
        f1_q[wr_q] <= op1;
        f2_q[wr_q] <= op2;
        wr_q       <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_opfetch.sv
// Randomized and directed bench for regfile_opfetch against a token-queue model.
// Build with +define+REGFILE_OPFETCH_X0_ZERO_EN to exercise register-0 handling.
module tb_regfile_opfetch;
  localparam int DL = 4;
  localparam int W  = 32;
`ifdef REGFILE_OPFETCH_X0_ZERO_EN
  localparam bit X0 = 1'b1;
`else
  localparam bit X0 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DL-1:0] in_rs1_addr = '0, in_rs2_addr = '0;
  logic          in_use_rs1 = 1'b0, in_use_rs2 = 1'b0;
  logic          wb_valid = 1'b0;
  logic [DL-1:0] wb_addr = '0;
  logic [W-1:0]  wb_data = '0;
  logic          rs1_read, rs2_read, rd_write;
  logic [DL-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [W-1:0]  rs1_rdata, rs2_rdata, rd_wdata;
  logic          out_valid, out_ready = 1'b1;
  logic [W-1:0]  out_rs1_data, out_rs2_data;

  always #5 clk = ~clk;

  regfile_opfetch #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_read(rs1_read), .rs1_addr(rs1_addr), .rs1_rdata(rs1_rdata),
    .rs2_read(rs2_read), .rs2_addr(rs2_addr), .rs2_rdata(rs2_rdata),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
  );

  // external regfile: one-cycle read latency, reads see pre-write contents
  logic [W-1:0] mem [16];
  always @(posedge clk) begin
    rs1_rdata <= rs1_read ? mem[rs1_addr] : W'($urandom);
    rs2_rdata <= rs2_read ? mem[rs2_addr] : W'($urandom);
    if (rd_write) mem[rd_addr] <= rd_wdata;
  end

  typedef struct {
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    int           c;
  } tok_t;

  tok_t         q[$];
  logic [W-1:0] ref_rf [16];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           n_fire = 0;
  int           n_pop = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit live(logic [DL-1:0] a);
    return !X0 || (a != '0);
  endfunction

  // one clock of stimulus: check against the model, advance the model
  task automatic step();
    logic eov, eir, efire, epop, ewr;
    tok_t t;
    #1;
    eov = 1'b0;
    if (rst_n && q.size() > 0) eov = (q[0].c + 2 <= cyc);
    eir   = rst_n && (q.size() < 2 || (eov && out_ready));
    efire = in_valid && eir;
    epop  = eov && out_ready;
    ewr   = rst_n && wb_valid && live(wb_addr);
    check("out_valid", 32'(out_valid), 32'(eov));
    check("in_ready", 32'(in_ready), 32'(eir));
    check("rs1_read", 32'(rs1_read), 32'(efire && in_use_rs1 && live(in_rs1_addr)));
    check("rs2_read", 32'(rs2_read), 32'(efire && in_use_rs2 && live(in_rs2_addr)));
    check("rd_write", 32'(rd_write), 32'(ewr));
    if (rs1_read) check("rs1_addr", 32'(rs1_addr), 32'(in_rs1_addr));
    if (ewr) check("rd_wdata", rd_wdata, wb_data);
    if (eov) begin
      check("op1", out_rs1_data, q[0].d1);
      check("op2", out_rs2_data, q[0].d2);
    end else begin
      check("op1_idle", out_rs1_data, '0);
    end
    if (epop) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (ewr) ref_rf[wb_addr] = wb_data;
    if (efire) begin
      t.d1 = (in_use_rs1 && live(in_rs1_addr)) ? ref_rf[in_rs1_addr] : '0;
      t.d2 = (in_use_rs2 && live(in_rs2_addr)) ? ref_rf[in_rs2_addr] : '0;
      t.c  = cyc;
      q.push_back(t);
      n_fire++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_use_rs1 = 1'b0;
    in_use_rs2 = 1'b0;
    wb_valid   = 1'b0;
    out_ready  = 1'b1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic issue(logic [DL-1:0] a1, logic [DL-1:0] a2, bit u1, bit u2);
    in_valid    = 1'b1;
    in_rs1_addr = a1;
    in_rs2_addr = a2;
    in_use_rs1  = u1;
    in_use_rs2  = u2;
  endtask

  task automatic wb(logic [DL-1:0] a, logic [W-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    int n0, p0;
    for (int i = 0; i < 16; i++) ref_rf[i] = '0;
    idle();
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wb(DL'(i), $urandom);
      step();
    end

    // wb x3 at T0, issue x3/x4 at T1, operands visible at T3
    wb(4'd4, 32'h11);
    step();
    wb(4'd3, 32'hDEADBEEF);
    step();
    wb_valid = 1'b0;
    issue(4'd3, 4'd4, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    #1;
    check("t028_ov", 32'(out_valid), 32'd1);
    check("t028_rs1", out_rs1_data, 32'hDEADBEEF);
    check("t028_rs2", out_rs2_data, 32'h00000011);
    drain();

    // same-cycle writeback is bypassed, a later one is not
    wb(4'd5, 32'h1234);
    issue(4'd5, 4'd5, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    wb(4'd5, 32'h9);
    step();
    wb_valid = 1'b0;
    #1;
    check("t029_rs1", out_rs1_data, 32'h00001234);
    check("t029_rs2", out_rs2_data, 32'h0);
    drain();

    // back-pressure: two accepted, third waits for the pop cycle
    out_ready = 1'b0;
    issue(4'd1, 4'd2, 1'b1, 1'b1);
    n0 = n_fire;
    repeat (3) step();
    check("t030_acc2", 32'(n_fire - n0), 32'd2);
    #1;
    check("t030_stall", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("t030_acc3", 32'(n_fire - n0), 32'd3);
    drain();

    // full throughput
    n0 = n_fire;
    p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      issue(DL'($urandom), DL'($urandom), 1'b1, 1'b1);
      step();
    end
    idle();
    repeat (2) step();
    check("t031_fires", 32'(n_fire - n0), 32'd8);
    check("t031_pops", 32'(n_pop - p0), 32'd8);

    // reset with the pipeline full
    out_ready = 1'b0;
    issue(4'd6, 4'd7, 1'b1, 1'b1);
    repeat (2) step();
    wb(4'd8, 32'hABCD);
    rst_n = 1'b0;
    #1;
    check("t032_ov", 32'(out_valid), 32'd0);
    check("t032_ir", 32'(in_ready), 32'd0);
    check("t032_strobes", 32'({rs1_read, rs2_read, rd_write}), 32'd0);
    check("t032_data", out_rs1_data | out_rs2_data, 32'd0);
    q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    idle();
    p0 = n_pop;
    issue(4'd6, 4'd7, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check("t032_one", 32'(n_pop - p0), 32'd1);

    // register 0 handling
    wb(4'd0, 32'h55);
    #1;
    check("t033_wr", 32'(rd_write), 32'(!X0));
    step();
    wb_valid = 1'b0;
    issue(4'd0, 4'd0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    #1;
    check("t033_rd", out_rs1_data, X0 ? 32'h0 : 32'h55);
    drain();

    // random traffic with hazards on a small address window
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(3) != 0);
      in_rs1_addr = DL'($urandom_range(3));
      in_rs2_addr = DL'($urandom_range(3));
      in_use_rs1  = $urandom_range(1) == 1;
      in_use_rs2  = $urandom_range(1) == 1;
      wb_valid    = $urandom_range(1) == 1;
      wb_addr     = DL'($urandom_range(3));
      wb_data     = $urandom;
      out_ready   = ($urandom_range(2) != 0);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
